// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the forwarding, self-initialising dual-port RAM.
package dp_ram_pkg;

    typedef enum logic {
        RDW_WRITE_FIRST = 1'b0,
        RDW_READ_FIRST  = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } init_state_e;

    // Widest word merge_bits can handle; DATA_WIDTH must stay below this.
    localparam int MAX_DATA_WIDTH = 512;
    typedef logic [MAX_DATA_WIDTH-1:0] merge_word_t;

    function automatic merge_word_t merge_bits(input merge_word_t old_word,
                                               input merge_word_t din,
                                               input merge_word_t mask);
        return (old_word & ~mask) | (din & mask);
    endfunction

endpackage

// File: rtl/dp_ram_init_seq.sv
// Post-reset initialisation sequencer: walks every word once, then reports READY.
module dp_ram_init_seq
    import dp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int DEPTH         = 2**ADDR_WIDTH,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  CLK,
    input  logic                  rst,
    output logic                  init_we,
    output logic [ADDR_WIDTH-1:0] init_addr,
    output logic                  INIT_DONE
);

    localparam init_state_e RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    init_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: defaults first so no path through this block leaves an output unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                cnt_d   = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign init_addr = cnt_q;
    assign INIT_DONE = (state_q == ST_READY);

endmodule

// File: rtl/dp_ram_fwd_init.sv
// Flop-array RAM: masked write port B, pipelined read port A with selectable
// read-during-write behaviour, sticky range error and post-reset init sweep.
module dp_ram_fwd_init
    import dp_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 4,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    DEPTH         = 2**ADDR_WIDTH,
    parameter int                    RD_LATENCY    = 1,
    parameter int                    RDW_MODE      = 0,
    parameter int                    INIT_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  CEA,
    input  logic [ADDR_WIDTH-1:0] AA,
    input  logic                  CEB,
    input  logic [ADDR_WIDTH-1:0] AB,
    input  logic [DATA_WIDTH-1:0] DB,
    input  logic [DATA_WIDTH-1:0] BWB,
    output logic [DATA_WIDTH-1:0] QA,
    output logic                  QA_VALID,
    output logic                  INIT_DONE,
    output logic                  ADDR_ERR
);

    localparam rdw_mode_e RDW = (RDW_MODE != 0) ? RDW_READ_FIRST : RDW_WRITE_FIRST;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  init_we;
    logic [ADDR_WIDTH-1:0] init_addr;

    dp_ram_init_seq #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DEPTH         (DEPTH),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_init_seq (
        .CLK       (CLK),
        .rst       (rst),
        .init_we   (init_we),
        .init_addr (init_addr),
        .INIT_DONE (INIT_DONE)
    );

    logic a_in_range, b_in_range, ready;
    logic rd_fire, port_we, collide;

    assign a_in_range = ({1'b0, AA} < DEPTH_L);
    assign b_in_range = ({1'b0, AB} < DEPTH_L);
    assign ready      = INIT_DONE;
    assign rd_fire    = ready && CEA;
    assign port_we    = ready && CEB && b_in_range;
    assign collide    = rd_fire && port_we && (AA == AB);

    logic [DATA_WIDTH-1:0] b_old, wr_merged;
    merge_word_t           merged_full;
    logic                  unused_merge_hi;

    assign b_old           = b_in_range ? mem[AB] : '0;
    assign merged_full     = merge_bits(merge_word_t'(b_old), merge_word_t'(DB), merge_word_t'(BWB));
    assign wr_merged       = merged_full[DATA_WIDTH-1:0];
    assign unused_merge_hi = ^merged_full[MAX_DATA_WIDTH-1:DATA_WIDTH];

    // The sweep owns the array while INIT is active; port B is locked out.
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_data;

    always_comb begin
        arr_we   = 1'b0;
        arr_addr = AB;
        arr_data = wr_merged;
        if (init_we) begin
            arr_we   = 1'b1;
            arr_addr = init_addr;
            arr_data = INIT_VALUE;
        end else if (port_we) begin
            arr_we = 1'b1;
        end
    end

    // NOTE: the storage array is deliberately left without reset; contents come from the sweep.
    always_ff @(posedge CLK) begin
        if (arr_we) begin
            mem[arr_addr] <= arr_data;
        end
    end

    logic [DATA_WIDTH-1:0] rd_word, s1_data;
    logic                  s1_valid;

    always_comb begin
        rd_word = '0;
        if (a_in_range) begin
            rd_word = (collide && RDW == RDW_WRITE_FIRST) ? wr_merged : mem[AA];
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s2_data;
            logic                  s2_valid;

            always_ff @(posedge CLK or posedge rst) begin
                if (rst) begin
                    s2_data  <= '0;
                    s2_valid <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign QA       = s2_data;
            assign QA_VALID = s2_valid;
        end else begin : g_lat1
            assign QA       = s1_data;
            assign QA_VALID = s1_valid;
        end
    endgenerate

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            ADDR_ERR <= 1'b0;
        end else if (ready && ((CEA && !a_in_range) || (CEB && !b_in_range))) begin
            ADDR_ERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dp_ram_fwd_init.sv
// Directed bench: four RAM configurations share one stimulus stream and are
// checked against hand-computed values.
module tb_dp_ram_fwd_init;

    localparam logic [31:0] IV   = 32'hA5A5A5A5;
    localparam logic [31:0] ONES = 32'hFFFFFFFF;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        CEA = 1'b0;
    logic [2:0]  AA  = '0;
    logic        CEB = 1'b0;
    logic [2:0]  AB  = '0;
    logic [31:0] DB  = '0;
    logic [31:0] BWB = '0;

    logic [31:0] qa_a, qa_b, qa_c, qa_d;
    logic        qv_a, qv_b, qv_c, qv_d;
    logic        done_a, done_b, done_c, done_d;
    logic        err_a, err_b, err_c, err_d;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    // a: depth 8, latency 1, write-first
    dp_ram_fwd_init #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .DEPTH(8), .RD_LATENCY(1),
                      .RDW_MODE(0), .INIT_ON_RESET(1), .INIT_VALUE(IV)) u_a (
        .CLK(CLK), .rst(rst), .CEA(CEA), .AA(AA), .CEB(CEB), .AB(AB), .DB(DB), .BWB(BWB),
        .QA(qa_a), .QA_VALID(qv_a), .INIT_DONE(done_a), .ADDR_ERR(err_a));

    // b: depth 8, latency 2, read-first
    dp_ram_fwd_init #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .DEPTH(8), .RD_LATENCY(2),
                      .RDW_MODE(1), .INIT_ON_RESET(1), .INIT_VALUE(IV)) u_b (
        .CLK(CLK), .rst(rst), .CEA(CEA), .AA(AA), .CEB(CEB), .AB(AB), .DB(DB), .BWB(BWB),
        .QA(qa_b), .QA_VALID(qv_b), .INIT_DONE(done_b), .ADDR_ERR(err_b));

    // c: depth 6 in a 3-bit address space, latency 1, write-first
    dp_ram_fwd_init #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .DEPTH(6), .RD_LATENCY(1),
                      .RDW_MODE(0), .INIT_ON_RESET(1), .INIT_VALUE(IV)) u_c (
        .CLK(CLK), .rst(rst), .CEA(CEA), .AA(AA), .CEB(CEB), .AB(AB), .DB(DB), .BWB(BWB),
        .QA(qa_c), .QA_VALID(qv_c), .INIT_DONE(done_c), .ADDR_ERR(err_c));

    // d: no init sweep, ready straight out of reset
    dp_ram_fwd_init #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .DEPTH(8), .RD_LATENCY(1),
                      .RDW_MODE(0), .INIT_ON_RESET(0), .INIT_VALUE(IV)) u_d (
        .CLK(CLK), .rst(rst), .CEA(CEA), .AA(AA), .CEB(CEB), .AB(AB), .DB(DB), .BWB(BWB),
        .QA(qa_d), .QA_VALID(qv_d), .INIT_DONE(done_d), .ADDR_ERR(err_d));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_wr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] m);
        CEB = 1'b1; AB = a; DB = d; BWB = m;
    endtask

    task automatic set_rd(input logic [2:0] a);
        CEA = 1'b1; AA = a;
    endtask

    task automatic idle();
        CEA = 1'b0; CEB = 1'b0;
    endtask

    initial begin
        int first_a, first_b, first_c;
        logic any_valid, any_err;
        first_a = 0; first_b = 0; first_c = 0;
        any_valid = 1'b0; any_err = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        @(negedge CLK);
        step();
        check("rst_qa_a",     qa_a,   32'h0);
        check("rst_qv_a",     qv_a,   32'h0);
        check("rst_err_a",    err_a,  32'h0);
        check("rst_done_a",   done_a, 32'h0);
        check("rst_qv_b",     qv_b,   32'h0);
        check("rst_done_c",   done_c, 32'h0);
        check("rst_done_noinit", done_d, 32'h1);

        // Sweep with ports poked, then reset at sweep cycle 4
        rst = 1'b0;
        set_rd(3'd7);
        set_wr(3'd3, 32'h0, ONES);
        for (int i = 0; i < 4; i++) step();
        check("sweep4_done_a", done_a, 32'h0);
        check("sweep4_qv_c",   qv_c,   32'h0);
        check("sweep4_err_c",  err_c,  32'h0);
        rst = 1'b1;
        #1;
        check("midrst_done_a", done_a, 32'h0);
        check("midrst_qa_b",   qa_b,   32'h0);
        @(negedge CLK);
        rst = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            step();
            if (done_a && first_a == 0) first_a = cyc;
            if (done_b && first_b == 0) first_b = cyc;
            if (done_c && first_c == 0) first_c = cyc;
            any_valid = any_valid | qv_a | qv_b | qv_c;
            any_err   = any_err | err_c;
            if (cyc == 5) idle();
        end
        check("init_cycles_a", first_a, 32'd8);
        check("init_cycles_b", first_b, 32'd8);
        check("init_cycles_c", first_c, 32'd6);
        check("init_no_valid", any_valid, 32'h0);
        check("init_no_err",   any_err,   32'h0);

        // Zero-mask write to addr 7: no-op for depth 8, range error for depth 6
        set_wr(3'd7, ONES, 32'h0);
        step();
        idle();
        check("oor_wr_err_c", err_c, 32'h1);
        check("oor_wr_err_a", err_a, 32'h0);

        // Pipelined read of every address
        for (int i = 0; i < 10; i++) begin
            if (i < 8) set_rd(3'(i));
            else idle();
            step();
            if (i < 8) begin
                check($sformatf("sweep_qa_a_%0d", i), qa_a, IV);
                check($sformatf("sweep_qv_a_%0d", i), qv_a, 32'h1);
                check($sformatf("sweep_qa_c_%0d", i), qa_c, (i < 6) ? IV : 32'h0);
                check($sformatf("sweep_qv_c_%0d", i), qv_c, 32'h1);
            end
            if (i >= 1 && i <= 8) begin
                check($sformatf("sweep_qa_b_%0d", i - 1), qa_b, IV);
                check($sformatf("sweep_qv_b_%0d", i - 1), qv_b, 32'h1);
            end
            if (i == 8) check("sweep_end_qv_a", qv_a, 32'h0);
            if (i == 9) check("sweep_end_qv_b", qv_b, 32'h0);
        end
        check("sweep_err_c_held", err_c, 32'h1);

        // Masked write then read-back at both latencies
        set_wr(3'd3, ONES, 32'h0000FFFF);
        step();
        CEB = 1'b0;
        set_rd(3'd3);
        step();
        idle();
        check("mask_qa_a", qa_a, 32'hA5A5FFFF);
        check("mask_qv_a", qv_a, 32'h1);
        check("mask_qa_c", qa_c, 32'hA5A5FFFF);
        check("mask_qv_b_early", qv_b, 32'h0);
        step();
        check("mask_qv_a_drop", qv_a, 32'h0);
        check("mask_qa_b", qa_b, 32'hA5A5FFFF);
        check("mask_qv_b", qv_b, 32'h1);

        // Read-during-write collision on addr 5
        set_wr(3'd5, 32'h11111111, ONES);
        step();
        set_wr(3'd5, 32'h22222222, ONES);
        set_rd(3'd5);
        step();
        idle();
        check("rdw_wf_qa_a", qa_a, 32'h22222222);
        check("rdw_wf_qa_c", qa_c, 32'h22222222);
        step();
        check("rdw_rf_qa_b", qa_b, 32'h11111111);
        set_rd(3'd5);
        step();
        idle();
        check("rdw_after_qa_a", qa_a, 32'h22222222);
        check("rdw_after_qa_c", qa_c, 32'h22222222);
        step();
        check("rdw_after_qa_b", qa_b, 32'h22222222);

        // Back-to-back reads of distinct words
        set_wr(3'd0, 32'h100, ONES); step();
        set_wr(3'd1, 32'h101, ONES); step();
        set_wr(3'd2, 32'h102, ONES); step();
        CEB = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j < 3) set_rd(3'(j));
            else idle();
            step();
            if (j < 3) begin
                check($sformatf("b2b_qa_a_%0d", j), qa_a, 32'h100 + 32'(j));
                check($sformatf("b2b_qv_a_%0d", j), qv_a, 32'h1);
            end
            if (j >= 1 && j <= 3) begin
                check($sformatf("b2b_qa_b_%0d", j - 1), qa_b, 32'h100 + 32'(j - 1));
                check($sformatf("b2b_qv_b_%0d", j - 1), qv_b, 32'h1);
            end
            if (j == 3) begin
                check("b2b_hold_qv_a", qv_a, 32'h0);
                check("b2b_hold_qa_a", qa_a, 32'h102);
            end
            if (j == 4) begin
                check("b2b_hold_qv_b", qv_b, 32'h0);
                check("b2b_hold_qa_b", qa_b, 32'h102);
            end
        end

        // Mixed in-range / out-of-range accesses on the depth-6 instance
        set_wr(3'd7, ONES, ONES);
        set_rd(3'd0);
        step();
        check("mix_rd_ok_qa_c", qa_c, 32'h100);
        check("mix_rd_ok_qv_c", qv_c, 32'h1);
        check("mix_err_c",      err_c, 32'h1);
        set_wr(3'd1, 32'h55, ONES);
        set_rd(3'd7);
        step();
        check("mix_oor_qa_c", qa_c, 32'h0);
        check("mix_oor_qv_c", qv_c, 32'h1);
        check("mix_a_addr7",  qa_a, ONES);
        CEB = 1'b0;
        set_rd(3'd1);
        step();
        idle();
        check("mix_wr_ok_qa_c", qa_c, 32'h55);
        step();
        check("hold_qa_c", qa_c, 32'h55);
        check("hold_qv_c", qv_c, 32'h0);

        // Asynchronous reset while READY clears outputs without a clock edge
        rst = 1'b1;
        #1;
        check("async_qa_c",   qa_c,   32'h0);
        check("async_err_c",  err_c,  32'h0);
        check("async_done_c", done_c, 32'h0);
        check("async_qa_a",   qa_a,   32'h0);
        check("async_done_d", done_d, 32'h1);
        @(negedge CLK);
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
